// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency
// completions are held in a one-entry buffer and retired into the busy scoreboard.
module rf_write_arbiter #(
  parameter int XLEN        = 32,
  parameter int NREGS       = 32,
  parameter int MAX_PENDING = 4,
  localparam int AW         = $clog2(NREGS),
  localparam int PW         = $clog2(MAX_PENDING + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid_i,
  input  logic [AW-1:0]   issue_rd_i,
  output logic            issue_ready_o,
  input  logic [AW-1:0]   rs1_i,
  input  logic [AW-1:0]   rs2_i,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  input  logic            wb_valid_i,
  input  logic [AW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            lat_valid_i,
  input  logic [AW-1:0]   lat_rd_i,
  input  logic [XLEN-1:0] lat_data_i,
  output logic            lat_ready_o,
  output logic            rf_wen_o,
  output logic [AW-1:0]   rf_rd_o,
  output logic [XLEN-1:0] rf_data_o,
  output logic [PW-1:0]   pending_o,
  output logic            err_o
);

  localparam logic [PW-1:0] MAX_P = PW'(MAX_PENDING);
  localparam logic [PW-1:0] ONE_P = PW'(1);

  // architectural control state
  logic [NREGS-1:0] busy;
  logic [PW-1:0]    pending;
  logic             err;

  // completion buffer (stage p1): the result waits here until WB leaves the port idle
  logic             vld_p1;
  logic [AW-1:0]    rd_p1;
  logic [XLEN-1:0]  data_p1;

  logic             wb_eff;
  logic             lat_eff;
  logic             drain;
  logic             lat_ready;
  logic             load;
  logic             issue_ready;
  logic             issue_set;
  logic             retire_dec;
  logic             viol;
  logic [NREGS-1:0] busy_next;

  // port arbitration, handshakes, scoreboard next-state and violation detection
  always_comb begin
    wb_eff      = wb_valid_i && (wb_rd_i != '0);
    lat_eff     = lat_valid_i && (lat_rd_i != '0);
    drain       = rst_n && !wb_eff && vld_p1;
    lat_ready   = rst_n && (!vld_p1 || drain);
    load        = lat_ready && lat_eff;
    // x0 issues carry no destination, so they never need a scoreboard slot
    issue_ready = rst_n && ((issue_rd_i == '0) ||
                            (!busy[issue_rd_i] && (pending < MAX_P)));
    issue_set   = issue_valid_i && issue_ready && (issue_rd_i != '0);
    // a result for a register that was never marked busy must not underflow the count
    retire_dec  = drain && busy[rd_p1];
    viol        = (wb_eff && busy[wb_rd_i]) || (load && !busy[lat_rd_i]);

    busy_next = busy;
    if (drain) busy_next[rd_p1] = 1'b0;
    if (issue_set) busy_next[issue_rd_i] = 1'b1;
    busy_next[0] = 1'b0;

    rf_wen_o  = 1'b0;
    rf_rd_o   = '0;
    rf_data_o = '0;
    if (rst_n && wb_eff) begin
      rf_wen_o  = 1'b1;
      rf_rd_o   = wb_rd_i;
      rf_data_o = wb_data_i;
    end else if (drain) begin
      rf_wen_o  = 1'b1;
      rf_rd_o   = rd_p1;
      rf_data_o = data_p1;
    end
  end

  // control state: scoreboard, pending count, buffer valid and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy    <= '0;
      pending <= '0;
      err     <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      busy <= busy_next;
      case ({issue_set, retire_dec})
        2'b10:   pending <= pending + ONE_P;
        2'b01:   pending <= pending - ONE_P;
        default: pending <= pending;
      endcase
      if (viol) err <= 1'b1;
      if (load) vld_p1 <= 1'b1;
      else if (drain) vld_p1 <= 1'b0;
    end
  end

  // buffer payload, qualified by vld_p1 so it needs no reset
  always_ff @(posedge clk) begin
    if (load) begin
      rd_p1   <= lat_rd_i;
      data_p1 <= lat_data_i;
    end
  end

  assign lat_ready_o   = lat_ready;
  assign issue_ready_o = issue_ready;
  assign rs1_busy_o    = rst_n && busy[rs1_i];
  assign rs2_busy_o    = rst_n && busy[rs2_i];
  assign pending_o     = pending;
  assign err_o         = err;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based reference model.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        issue_ready_o;
  logic [4:0]  rs1_i, rs2_i;
  logic        rs1_busy_o, rs2_busy_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        lat_valid_i;
  logic [4:0]  lat_rd_i;
  logic [31:0] lat_data_i;
  logic        lat_ready_o;
  logic        rf_wen_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_data_o;
  logic [2:0]  pending_o;
  logic        err_o;

  rf_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .lat_valid_i(lat_valid_i), .lat_rd_i(lat_rd_i), .lat_data_i(lat_data_i),
    .lat_ready_o(lat_ready_o),
    .rf_wen_o(rf_wen_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o),
    .pending_o(pending_o), .err_o(err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // busy set of registers, pending = number of busy registers, buffer as a queue
  bit [31:0]   busy_m;
  logic [4:0]  bq_rd[$];
  logic [31:0] bq_data[$];
  bit          err_m;
  bit          started;
  bit          last_lat_acc;
  logic [4:0]  outstanding[$];

  logic        e_wb_eff, e_drain, e_lat_ready, e_issue_ready, e_wen;
  logic [4:0]  e_rd;
  logic [31:0] e_data;

  task automatic model_comb();
    e_wb_eff      = wb_valid_i && (wb_rd_i != 5'd0);
    e_drain       = rst_n && !e_wb_eff && (bq_rd.size() > 0);
    e_lat_ready   = rst_n && ((bq_rd.size() == 0) || e_drain);
    e_issue_ready = rst_n && ((issue_rd_i == 5'd0) ||
                              (!busy_m[issue_rd_i] && ($countones(busy_m) < 4)));
    e_wen  = rst_n && (e_wb_eff || (bq_rd.size() > 0));
    e_rd   = 5'd0;
    e_data = 32'd0;
    if (e_wb_eff) begin
      e_rd = wb_rd_i; e_data = wb_data_i;
    end else if (bq_rd.size() > 0) begin
      e_rd = bq_rd[0]; e_data = bq_data[0];
    end
  endtask

  task automatic model_check();
    model_comb();
    check1("issue_ready", issue_ready_o, e_issue_ready);
    check1("lat_ready", lat_ready_o, e_lat_ready);
    check1("rf_wen", rf_wen_o, e_wen);
    if (e_wen) begin
      check32("rf_rd", 32'(rf_rd_o), 32'(e_rd));
      check32("rf_data", rf_data_o, e_data);
    end
    check1("rs1_busy", rs1_busy_o, rst_n && busy_m[rs1_i]);
    check1("rs2_busy", rs2_busy_o, rst_n && busy_m[rs2_i]);
    check32("pending", 32'(pending_o), 32'($countones(busy_m)));
    check1("err", err_o, err_m);
  endtask

  task automatic model_update();
    bit [31:0] old;
    bit lacc, iacc;
    if (!rst_n) begin
      busy_m = '0;
      bq_rd.delete();
      bq_data.delete();
      err_m = 1'b0;
      outstanding.delete();
      last_lat_acc = 1'b0;
      started = 1'b1;
    end else begin
      model_comb();
      old  = busy_m;
      lacc = lat_valid_i && e_lat_ready;
      iacc = issue_valid_i && e_issue_ready;
      if (e_wb_eff && old[wb_rd_i]) err_m = 1'b1;
      if (lacc && (lat_rd_i != 5'd0) && !old[lat_rd_i]) err_m = 1'b1;
      if (e_drain) begin
        busy_m[bq_rd[0]] = 1'b0;
        void'(bq_rd.pop_front());
        void'(bq_data.pop_front());
      end
      if (iacc && (issue_rd_i != 5'd0)) begin
        busy_m[issue_rd_i] = 1'b1;
        outstanding.push_back(issue_rd_i);
      end
      if (lacc && (lat_rd_i != 5'd0)) begin
        bq_rd.push_back(lat_rd_i);
        bq_data.push_back(lat_data_i);
      end
      last_lat_acc = lacc;
    end
  endtask

  initial begin
    started = 1'b0;
    forever begin
      @(negedge clk);
      if (started) model_check();
      @(posedge clk);
      model_update();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    issue_valid_i = 1'b0; issue_rd_i = 5'd0;
    wb_valid_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'd0;
    lat_valid_i = 1'b0; lat_rd_i = 5'd0; lat_data_i = 32'd0;
    rs1_i = 5'd0; rs2_i = 5'd0;
  endtask

  task automatic do_reset();
    tick();
    idle_in();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    int k;
    logic [4:0] fill [4];
    fill[0] = 5'd3; fill[1] = 5'd4; fill[2] = 5'd6; fill[3] = 5'd8;
    rst_n = 1'b0;
    idle_in();

    // reset then idle
    tick(); tick();
    @(negedge clk);
    check1("rst_wen", rf_wen_o, 1'b0);
    check1("rst_issue_ready", issue_ready_o, 1'b0);
    check1("rst_lat_ready", lat_ready_o, 1'b0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    check1("idle_issue_ready", issue_ready_o, 1'b1);
    check1("idle_lat_ready", lat_ready_o, 1'b1);
    check1("idle_wen", rf_wen_o, 1'b0);
    check32("idle_pending", 32'(pending_o), 32'd0);

    // issue rd5 then its result with no WB
    tick(); issue_valid_i = 1'b1; issue_rd_i = 5'd5; rs1_i = 5'd5;
    @(negedge clk);
    check1("i5_ready", issue_ready_o, 1'b1);
    check1("i5_rs1_pre", rs1_busy_o, 1'b0);
    tick(); issue_valid_i = 1'b0;
    @(negedge clk);
    check1("i5_rs1_busy", rs1_busy_o, 1'b1);
    check32("i5_pending", 32'(pending_o), 32'd1);
    tick(); lat_valid_i = 1'b1; lat_rd_i = 5'd5; lat_data_i = 32'hDEADBEEF;
    @(negedge clk);
    check1("l5_ready", lat_ready_o, 1'b1);
    check1("l5_wen_early", rf_wen_o, 1'b0);
    tick(); lat_valid_i = 1'b0;
    @(negedge clk);
    check1("l5_wen", rf_wen_o, 1'b1);
    check32("l5_rd", 32'(rf_rd_o), 32'd5);
    check32("l5_data", rf_data_o, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    check1("l5_rs1_clear", rs1_busy_o, 1'b0);
    check32("l5_pending", 32'(pending_o), 32'd0);

    // result held in the buffer while WB owns the port
    tick(); issue_valid_i = 1'b1; issue_rd_i = 5'd7;
    tick(); issue_valid_i = 1'b0;
    wb_valid_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'hA1;
    lat_valid_i = 1'b1; lat_rd_i = 5'd7; lat_data_i = 32'h11;
    @(negedge clk);
    check32("wb1_rd", 32'(rf_rd_o), 32'd1);
    check32("wb1_data", rf_data_o, 32'hA1);
    check1("wb1_lat_ready", lat_ready_o, 1'b1);
    tick(); lat_valid_i = 1'b0; wb_rd_i = 5'd2; wb_data_i = 32'hA2;
    @(negedge clk);
    check1("wb2_lat_ready", lat_ready_o, 1'b0);
    check32("wb2_rd", 32'(rf_rd_o), 32'd2);
    tick(); wb_rd_i = 5'd3; wb_data_i = 32'hA3;
    @(negedge clk);
    check1("wb3_lat_ready", lat_ready_o, 1'b0);
    check32("wb3_data", rf_data_o, 32'hA3);
    tick(); wb_valid_i = 1'b0;
    @(negedge clk);
    check1("buf7_wen", rf_wen_o, 1'b1);
    check32("buf7_rd", 32'(rf_rd_o), 32'd7);
    check32("buf7_data", rf_data_o, 32'h11);
    tick();
    @(negedge clk);
    check32("buf7_pending", 32'(pending_o), 32'd0);

    // fill the pending limit
    for (int i = 0; i < 4; i++) begin
      tick(); issue_valid_i = 1'b1; issue_rd_i = fill[i];
    end
    tick(); issue_valid_i = 1'b0; issue_rd_i = 5'd9;
    @(negedge clk);
    check32("full_pending", 32'(pending_o), 32'd4);
    check1("full_ready9", issue_ready_o, 1'b0);
    tick(); lat_valid_i = 1'b1; lat_rd_i = 5'd3; lat_data_i = 32'h33;
    tick(); lat_valid_i = 1'b0;
    @(negedge clk);
    check1("ret3_wen", rf_wen_o, 1'b1);
    check1("ret3_same_cycle_ready", issue_ready_o, 1'b0);
    tick();
    @(negedge clk);
    check1("ret3_ready9", issue_ready_o, 1'b1);
    check32("ret3_pending", 32'(pending_o), 32'd3);
    tick(); issue_rd_i = 5'd4;
    @(negedge clk);
    check1("busy4_ready", issue_ready_o, 1'b0);
    // back-to-back results, one per cycle
    tick(); lat_valid_i = 1'b1; lat_rd_i = 5'd4; lat_data_i = 32'h44;
    tick(); lat_rd_i = 5'd6; lat_data_i = 32'h66;
    @(negedge clk);
    check1("b2b_lat_ready", lat_ready_o, 1'b1);
    check32("b2b_rd4", 32'(rf_rd_o), 32'd4);
    tick(); lat_rd_i = 5'd8; lat_data_i = 32'h88;
    tick(); lat_valid_i = 1'b0;
    @(negedge clk);
    check32("b2b_rd8", 32'(rf_rd_o), 32'd8);
    tick();
    @(negedge clk);
    check32("b2b_pending", 32'(pending_o), 32'd0);

    // x0 handling
    tick(); issue_valid_i = 1'b1; issue_rd_i = 5'd0;
    @(negedge clk);
    check1("x0_issue_ready", issue_ready_o, 1'b1);
    tick(); issue_valid_i = 1'b0; lat_valid_i = 1'b1; lat_rd_i = 5'd0; lat_data_i = 32'h55;
    @(negedge clk);
    check1("x0_lat_ready", lat_ready_o, 1'b1);
    check32("x0_pending", 32'(pending_o), 32'd0);
    tick(); lat_valid_i = 1'b0; wb_valid_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'h66;
    @(negedge clk);
    check1("x0_lat_nowrite", rf_wen_o, 1'b0);
    tick(); wb_valid_i = 1'b0;
    @(negedge clk);
    check1("x0_wb_nowrite", rf_wen_o, 1'b0);
    check1("x0_err", err_o, 1'b0);

    // randomized legal traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!(lat_valid_i && !last_lat_acc)) begin
        lat_valid_i = 1'b0;
        r = $urandom_range(0, 99);
        if (r < 45 && outstanding.size() > 0) begin
          k = $urandom_range(0, outstanding.size() - 1);
          lat_rd_i = outstanding[k];
          outstanding.delete(k);
          lat_data_i = $urandom;
          lat_valid_i = 1'b1;
        end else if (r >= 90) begin
          lat_rd_i = 5'd0;
          lat_data_i = $urandom;
          lat_valid_i = 1'b1;
        end
      end
      issue_valid_i = ($urandom_range(0, 2) == 0);
      issue_rd_i    = 5'($urandom_range(0, 15));
      wb_rd_i       = 5'($urandom_range(0, 15));
      wb_valid_i    = ($urandom_range(0, 1) == 1) && !busy_m[wb_rd_i];
      wb_data_i     = $urandom;
      rs1_i         = 5'($urandom_range(0, 15));
      rs2_i         = 5'($urandom_range(0, 15));
    end

    // reset in the middle of a drain
    do_reset();
    tick(); issue_valid_i = 1'b1; issue_rd_i = 5'd10; rs1_i = 5'd10;
    tick(); issue_valid_i = 1'b0; lat_valid_i = 1'b1; lat_rd_i = 5'd10; lat_data_i = 32'hAA;
    tick(); lat_valid_i = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check1("mid_rst_wen", rf_wen_o, 1'b0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    check1("mid_rst_busy", rs1_busy_o, 1'b0);
    check1("mid_rst_wen_after", rf_wen_o, 1'b0);
    check32("mid_rst_pending", 32'(pending_o), 32'd0);

    // WAW violation
    tick(); issue_valid_i = 1'b1; issue_rd_i = 5'd5;
    tick(); issue_valid_i = 1'b0; wb_valid_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h1;
    @(negedge clk);
    check1("waw_err_before", err_o, 1'b0);
    tick(); wb_valid_i = 1'b0;
    @(negedge clk);
    check1("waw_err", err_o, 1'b1);
    tick(); tick();
    @(negedge clk);
    check1("waw_err_held", err_o, 1'b1);

    // result for a register that was never issued
    do_reset();
    @(negedge clk);
    check1("err_cleared", err_o, 1'b0);
    tick(); lat_valid_i = 1'b1; lat_rd_i = 5'd12; lat_data_i = 32'hC12;
    @(negedge clk);
    check1("stray_lat_ready", lat_ready_o, 1'b1);
    tick(); lat_valid_i = 1'b0;
    @(negedge clk);
    check1("stray_err", err_o, 1'b1);
    check1("stray_wen", rf_wen_o, 1'b1);
    check32("stray_rd", 32'(rf_rd_o), 32'd12);
    check32("stray_data", rf_data_o, 32'hC12);
    tick();
    @(negedge clk);
    check32("stray_pending", 32'(pending_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback and a long-latency completion source, for example a multi-cycle mul/div unit.
- Keeps a per-register busy scoreboard for outstanding long-latency destinations, which the hazard logic queries on rs1/rs2.
- Holds one completion result in a buffer whenever pipeline writeback owns the port.
- Sits between the WB stage, the long-latency unit and the register-file write inputs (wen/rd/rd_data).

Parameters:
- XLEN, 32, data width.
- NREGS, 32, number of architectural registers; the address width is clog2(NREGS) = 5.
- MAX_PENDING, 4, maximum number of long-latency ops in flight.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- issue_valid_i  in  1  a long-latency op wants to issue.
- issue_rd_i  in  5  destination of the issuing op.
- issue_ready_o  out  1  issue accepted this cycle.
- rs1_i  in  5  hazard query address.
- rs2_i  in  5  hazard query address.
- rs1_busy_o  out  1  rs1 has an outstanding long-latency write.
- rs2_busy_o  out  1  rs2 has an outstanding long-latency write.
- wb_valid_i  in  1  pipeline writeback request; never stalled.
- wb_rd_i  in  5  pipeline writeback destination.
- wb_data_i  in  XLEN  pipeline writeback data.
- lat_valid_i  in  1  long-latency result valid.
- lat_rd_i  in  5  long-latency result destination.
- lat_data_i  in  XLEN  long-latency result data.
- lat_ready_o  out  1  result accepted this cycle.
- rf_wen_o  out  1  register-file write enable.
- rf_rd_o  out  5  register-file write address.
- rf_data_o  out  XLEN  register-file write data.
- pending_o  out  3  count of outstanding ops.
- err_o  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst_n=0 at a posedge):
  - busy[] cleared, buffer empty, pending=0, err_o=0.
  - While rst_n=0, all ready/enable outputs are forced to 0: issue_ready_o, lat_ready_o, rf_wen_o, rs*_busy_o.
  - Reset mid-operation discards the buffered result and all pending state; no write is emitted.
- Internal signals:
  - wb_eff = wb_valid_i && wb_rd_i!=0.
  - lat_eff = lat_valid_i && lat_rd_i!=0.
- Write port, combinational:
  - If wb_eff: rf_* = wb_*, with wen=1.
  - Else if buf_valid: rf_* = buffer contents, wen=1, drain=1.
  - Else: wen=0, and rd/data=0.
  - Pipeline WB always has priority.
- Completion accept:
  - lat_ready_o = !buf_valid || drain.
  - Acceptance with lat_eff loads the buffer at the posedge, so the write reaches rf_wen_o ≥1 cycle later.
  - Drain and load in the same cycle are legal, giving a throughput of 1 result/cycle while WB is idle.
  - lat_valid_i with lat_rd_i=0 is accepted and discarded: no buffer load, no write.
- Retire: on a drain edge, busy[buf_rd] ← 0 and buf_valid ← 0 (unless reloaded in the same cycle).
- Issue:
  - issue_ready_o = !busy[issue_rd_i] && pending < MAX_PENDING, evaluated on registered state only; a same-cycle retire does not enable issue.
  - Accepted issue with rd≠0: busy[rd] ← 1 and pending+1.
  - rd=0 is always accepted, with no busy bit and no count change.
- Pending counter: simultaneous issue and retire leaves pending unchanged.
- Queries:
  - rsN_busy_o = busy[rsN_i], combinational.
  - Register 0 is never busy.
- err_o, set and held until reset, on any of:
  - wb_eff to a busy register (WAW violation);
  - an accepted lat_eff whose rd is not busy;
  - lat_valid_i held while lat_ready_o=0 is legal and is not an error.
- The source must hold lat_* stable until accepted.

Test Plan:
- Reset then idle:
  - issue_ready_o=1, lat_ready_o=1, rf_wen_o=0, pending_o=0.
  - Asserting rst_n=0 mid-drain → rf_wen_o=0 and busy cleared on the next cycle.
- Issue rd=5, then result lat_rd=5, data=0xDEADBEEF, with no WB:
  - rs1_i=5 → busy=1 from the cycle after issue.
  - rf_wen_o=1, rd=5, data=0xDEADBEEF one cycle after accept.
  - busy[5]=0 and pending_o=0 afterwards.
- Result accepted while wb_valid_i=1 (rd=7, 0x11) for 3 consecutive cycles:
  - rf_* carries the WB writes.
  - lat_ready_o=0 while the buffer is full.
  - The buffered write appears in the first WB-idle cycle.
- Issue rd=3,4,6,8 → pending_o=4 and issue_ready_o=0 for rd=9. Then:
  - retire one → ready next cycle;
  - a repeat issue to busy rd=4 → issue_ready_o=0.
- x0 handling:
  - issue rd=0 → accepted, pending unchanged.
  - lat result rd=0 → lat_ready_o=1, rf_wen_o=0.
  - wb rd=0 → rf_wen_o=0.
- Violations:
  - WB to busy rd=5 → err_o=1 next cycle and held.
  - Lat result to non-busy rd=12 → err_o=1, and the write is still performed.
